// File: rtl/axi_isolate_if.sv
// Bus bundle for one side of an axi_isolate link: the request/response struct pair
// with master/slave views.
interface axi_isolate_if #(
  parameter type req_t  = logic,
  parameter type resp_t = logic
);
  req_t  req;
  resp_t resp;

  modport master (output req, input  resp);
  modport slave  (input  req, output resp);
endinterface

// File: rtl/axi_isolate.sv
// axi_isolate: stops accepting new AW/AR on request, lets in-flight bursts finish,
// then reports the link isolated. All channels pass through combinationally.
package axi_isolate_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_isolate #(
  parameter int unsigned NumPending = 16,
  parameter type         req_t      = axi_isolate_pkg::axi_req_t,
  parameter type         resp_t     = axi_isolate_pkg::axi_resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i,
  input  logic  isolate_i,
  output logic  isolated_o
);

  localparam int unsigned     CntW   = $clog2(NumPending + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(NumPending);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    NORMAL,
    HOLD,
    DRAIN,
    ISOLATE
  } state_e;

  state_e          wr_state_q, rd_state_q;
  logic [CntW-1:0] wr_cnt_q, rd_cnt_q;

  logic aw_pass, ar_pass;
  logic aw_hs, ar_hs, b_hs, r_last_hs;
  logic aw_stall, ar_stall;

  assign aw_pass = ((wr_state_q == NORMAL) && (wr_cnt_q < CntMax)) || (wr_state_q == HOLD);
  assign ar_pass = ((rd_state_q == NORMAL) && (rd_cnt_q < CntMax)) || (rd_state_q == HOLD);

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;
    if (!aw_pass) begin
      mst_req_o.aw_valid  = 1'b0;
      slv_resp_o.aw_ready = 1'b0;
    end
    if (!ar_pass) begin
      mst_req_o.ar_valid  = 1'b0;
      slv_resp_o.ar_ready = 1'b0;
    end
  end

  assign aw_hs     = aw_pass & slv_req_i.aw_valid & mst_resp_i.aw_ready;
  assign ar_hs     = ar_pass & slv_req_i.ar_valid & mst_resp_i.ar_ready;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

  // A downstream-visible valid that is not yet accepted must stay valid, so the
  // FSM parks in HOLD (still passing) until that handshake completes.
  assign aw_stall = aw_pass & slv_req_i.aw_valid & ~mst_resp_i.aw_ready;
  assign ar_stall = ar_pass & slv_req_i.ar_valid & ~mst_resp_i.ar_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= NORMAL;
      wr_cnt_q   <= '0;
    end else begin
      assert (!(b_hs && (wr_cnt_q == '0)))
        else $error("axi_isolate: B handshake with no write outstanding");
      if (aw_hs && !b_hs) begin
        wr_cnt_q <= wr_cnt_q + CntOne;
      end else if (b_hs && !aw_hs) begin
        wr_cnt_q <= wr_cnt_q - CntOne;
      end
      unique case (wr_state_q)
        NORMAL:  if (isolate_i) wr_state_q <= aw_stall ? HOLD : DRAIN;
        HOLD:    if (aw_hs) wr_state_q <= DRAIN;
        DRAIN: begin
          if (wr_cnt_q == '0)  wr_state_q <= ISOLATE;
          else if (!isolate_i) wr_state_q <= NORMAL;
        end
        ISOLATE: if (!isolate_i) wr_state_q <= NORMAL;
        default: wr_state_q <= NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= NORMAL;
      rd_cnt_q   <= '0;
    end else begin
      assert (!(r_last_hs && (rd_cnt_q == '0)))
        else $error("axi_isolate: last R handshake with no read outstanding");
      if (ar_hs && !r_last_hs) begin
        rd_cnt_q <= rd_cnt_q + CntOne;
      end else if (r_last_hs && !ar_hs) begin
        rd_cnt_q <= rd_cnt_q - CntOne;
      end
      unique case (rd_state_q)
        NORMAL:  if (isolate_i) rd_state_q <= ar_stall ? HOLD : DRAIN;
        HOLD:    if (ar_hs) rd_state_q <= DRAIN;
        DRAIN: begin
          if (rd_cnt_q == '0)  rd_state_q <= ISOLATE;
          else if (!isolate_i) rd_state_q <= NORMAL;
        end
        ISOLATE: if (!isolate_i) rd_state_q <= NORMAL;
        default: rd_state_q <= NORMAL;
      endcase
    end
  end

  assign isolated_o = (wr_state_q == ISOLATE) && (rd_state_q == ISOLATE);

endmodule

// File: tb/tb_axi_isolate.sv
// Directed and randomized bench for axi_isolate with a transaction-level reference
// model tracking outstanding counts and the isolation phase of each direction.
module tb_axi_isolate;
  import axi_isolate_pkg::*;

  localparam int NP = 2;
  localparam int OPEN = 0, STUCK = 1, DRAINING = 2, SHUT = 3;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      isolate;
  logic      isolated;
  axi_req_t  s_req;
  axi_resp_t m_resp;

  axi_isolate_if #(.req_t(axi_req_t), .resp_t(axi_resp_t)) slv_bus ();
  axi_isolate_if #(.req_t(axi_req_t), .resp_t(axi_resp_t)) mst_bus ();

  assign slv_bus.req  = s_req;
  assign mst_bus.resp = m_resp;

  axi_isolate #(.NumPending(NP), .req_t(axi_req_t), .resp_t(axi_resp_t)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (slv_bus.req),
    .slv_resp_o (slv_bus.resp),
    .mst_req_o  (mst_bus.req),
    .mst_resp_i (mst_bus.resp),
    .isolate_i  (isolate),
    .isolated_o (isolated)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        failures = 0;
  int        ph [2];
  int        cnt [2];
  logic      obs_iso;
  axi_req_t  obs_req;
  axi_resp_t obs_resp;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // New addresses flow while open with room left, or while finishing a stuck one.
  function automatic bit passes(int p, int c);
    return ((p == OPEN) && (c < NP)) || (p == STUCK);
  endfunction

  function automatic int next_phase(int p, bit iso, bit stuck, bit addr_hs, int c);
    case (p)
      OPEN:     return !iso ? OPEN : (stuck ? STUCK : DRAINING);
      STUCK:    return addr_hs ? DRAINING : STUCK;
      DRAINING: return (c == 0) ? SHUT : (!iso ? OPEN : DRAINING);
      default:  return iso ? SHUT : OPEN;
    endcase
  endfunction

  task automatic rand_payload();
    s_req.aw.id    = 4'($urandom);
    s_req.aw.addr  = $urandom;
    s_req.aw.len   = 8'($urandom);
    s_req.ar.id    = 4'($urandom);
    s_req.ar.addr  = $urandom;
    s_req.ar.len   = 8'($urandom);
    s_req.w.data   = $urandom;
    s_req.w.strb   = 4'($urandom);
    s_req.w.last   = 1'($urandom);
    m_resp.b.id    = 4'($urandom);
    m_resp.b.resp  = 2'($urandom);
    m_resp.r.id    = 4'($urandom);
    m_resp.r.data  = $urandom;
    m_resp.r.resp  = 2'($urandom);
    m_resp.r.last  = 1'($urandom);
  endtask

  // One clock: inputs already set at the falling edge; compare, then advance the model.
  task automatic step();
    axi_req_t  er;
    axi_resp_t es;
    bit wp, rp, wv, rv, whs, rhs, wdec, rdec;
    #1;
    if (!rst_n) begin
      ph  = '{OPEN, OPEN};
      cnt = '{0, 0};
    end
    wp = passes(ph[0], cnt[0]);
    rp = passes(ph[1], cnt[1]);
    er = s_req;
    es = m_resp;
    if (!wp) begin er.aw_valid = 1'b0; es.aw_ready = 1'b0; end
    if (!rp) begin er.ar_valid = 1'b0; es.ar_ready = 1'b0; end
    obs_req  = mst_bus.req;
    obs_resp = slv_bus.resp;
    obs_iso  = isolated;
    check("mst_req", 256'(obs_req), 256'(er));
    check("slv_resp", 256'(obs_resp), 256'(es));
    check("isolated", 256'(obs_iso), 256'((ph[0] == SHUT) && (ph[1] == SHUT)));
    if (rst_n) begin
      wv   = wp && s_req.aw_valid;
      rv   = rp && s_req.ar_valid;
      whs  = wv && m_resp.aw_ready;
      rhs  = rv && m_resp.ar_ready;
      wdec = m_resp.b_valid && s_req.b_ready;
      rdec = m_resp.r_valid && s_req.r_ready && m_resp.r.last;
      ph[0] = next_phase(ph[0], isolate, wv && !m_resp.aw_ready, whs, cnt[0]);
      ph[1] = next_phase(ph[1], isolate, rv && !m_resp.ar_ready, rhs, cnt[1]);
      cnt[0] += int'(whs) - int'(wdec);
      cnt[1] += int'(rhs) - int'(rdec);
    end
    @(negedge clk);
  endtask

  task automatic write_txn();
    rand_payload();
    s_req.aw_valid = 1'b1; m_resp.aw_ready = 1'b1;
    step();
    s_req.aw_valid = 1'b0; m_resp.aw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      s_req.w_valid = 1'b1; s_req.w.last = (i == 3); m_resp.w_ready = 1'b1;
      step();
      check("w_beat", 256'(obs_req.w), 256'(s_req.w));
    end
    s_req.w_valid = 1'b0; m_resp.w_ready = 1'b0;
    rand_payload();
    m_resp.b_valid = 1'b1; s_req.b_ready = 1'b1;
    step();
    check("b_beat", 256'(obs_resp.b), 256'(m_resp.b));
    m_resp.b_valid = 1'b0; s_req.b_ready = 1'b0;
  endtask

  task automatic read_txn();
    rand_payload();
    s_req.ar_valid = 1'b1; m_resp.ar_ready = 1'b1;
    step();
    s_req.ar_valid = 1'b0; m_resp.ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      m_resp.r_valid = 1'b1; m_resp.r.last = (i == 3); s_req.r_ready = 1'b1;
      step();
      check("r_beat", 256'(obs_resp.r), 256'(m_resp.r));
    end
    m_resp.r_valid = 1'b0; s_req.r_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; isolate = 1'b0; s_req = '0; m_resp = '0;
    ph = '{OPEN, OPEN}; cnt = '{0, 0};
    @(negedge clk);

    // Reset: pass-through of valid/ready, not isolated
    s_req.aw_valid = 1'b1; m_resp.aw_ready = 1'b1;
    step(); step();
    check("reset_isolated", 256'(obs_iso), 256'(0));
    check("reset_aw_valid", 256'(obs_req.aw_valid), 256'(1));
    check("reset_aw_ready", 256'(obs_resp.aw_ready), 256'(1));
    rst_n = 1'b1; s_req = '0; m_resp = '0;
    step();

    // Pass-through bursts
    for (int k = 0; k < 4; k++) begin
      write_txn();
      read_txn();
    end
    check("pass_isolated", 256'(obs_iso), 256'(0));

    // Idle isolate: isolated two cycles after the request
    isolate = 1'b1;
    step(); check("idle_iso_t0", 256'(obs_iso), 256'(0));
    step(); check("idle_iso_t1", 256'(obs_iso), 256'(0));
    step(); check("idle_iso_t2", 256'(obs_iso), 256'(1));
    s_req.aw_valid = 1'b1; s_req.ar_valid = 1'b1;
    m_resp.aw_ready = 1'b1; m_resp.ar_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("iso_aw_valid", 256'(obs_req.aw_valid), 256'(0));
      check("iso_aw_ready", 256'(obs_resp.aw_ready), 256'(0));
      check("iso_ar_valid", 256'(obs_req.ar_valid), 256'(0));
      check("iso_ar_ready", 256'(obs_resp.ar_ready), 256'(0));
    end
    isolate = 1'b0;
    step(); check("release_t0_aw_ready", 256'(obs_resp.aw_ready), 256'(0));
    step(); check("release_t1_aw_ready", 256'(obs_resp.aw_ready), 256'(1));
    check("release_t1_ar_ready", 256'(obs_resp.ar_ready), 256'(1));
    s_req.aw_valid = 1'b0; s_req.ar_valid = 1'b0;
    m_resp.aw_ready = 1'b0; m_resp.ar_ready = 1'b0;
    m_resp.b_valid = 1'b1; s_req.b_ready = 1'b1;
    step();
    m_resp.b_valid = 1'b0; s_req.b_ready = 1'b0;
    m_resp.r_valid = 1'b1; m_resp.r.last = 1'b1; s_req.r_ready = 1'b1;
    step();
    m_resp.r_valid = 1'b0; s_req.r_ready = 1'b0;

    // Drain: one write and one read in flight when isolation starts
    s_req.aw_valid = 1'b1; m_resp.aw_ready = 1'b1;
    s_req.ar_valid = 1'b1; m_resp.ar_ready = 1'b1;
    step();
    s_req.aw_valid = 1'b0; s_req.ar_valid = 1'b0;
    isolate = 1'b1;
    step();
    s_req.aw_valid = 1'b1; s_req.ar_valid = 1'b1;
    step();
    check("drain_aw_blocked", 256'(obs_resp.aw_ready), 256'(0));
    check("drain_ar_blocked", 256'(obs_req.ar_valid), 256'(0));
    m_resp.b_valid = 1'b1; s_req.b_ready = 1'b1;
    step();
    m_resp.b_valid = 1'b0; s_req.b_ready = 1'b0;
    s_req.r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      m_resp.r_valid = 1'b1; m_resp.r.last = (i == 3);
      step();
      check("drain_r_beat", 256'(obs_resp.r), 256'(m_resp.r));
    end
    check("drain_iso_last", 256'(obs_iso), 256'(0));
    m_resp.r_valid = 1'b0; s_req.r_ready = 1'b0;
    step(); check("drain_iso_last_p1", 256'(obs_iso), 256'(0));
    step(); check("drain_iso_last_p2", 256'(obs_iso), 256'(1));

    // HOLD: AW stuck when isolation starts, accepted three cycles later
    isolate = 1'b0; s_req.aw_valid = 1'b0; s_req.ar_valid = 1'b0;
    m_resp.aw_ready = 1'b0; m_resp.ar_ready = 1'b0;
    step();
    s_req.aw_valid = 1'b1; isolate = 1'b1;
    step(); check("hold_t0_aw_valid", 256'(obs_req.aw_valid), 256'(1));
    step(); check("hold_t1_aw_valid", 256'(obs_req.aw_valid), 256'(1));
    step(); check("hold_t2_aw_valid", 256'(obs_req.aw_valid), 256'(1));
    m_resp.aw_ready = 1'b1;
    step(); check("hold_t3_aw_valid", 256'(obs_req.aw_valid), 256'(1));
    check("hold_t3_aw_ready", 256'(obs_resp.aw_ready), 256'(1));
    s_req.aw_valid = 1'b0; m_resp.aw_ready = 1'b0;
    m_resp.b_valid = 1'b1; s_req.b_ready = 1'b1;
    step(); check("hold_b_iso", 256'(obs_iso), 256'(0));
    m_resp.b_valid = 1'b0; s_req.b_ready = 1'b0;
    step(); check("hold_b_iso_p1", 256'(obs_iso), 256'(0));
    step(); check("hold_b_iso_p2", 256'(obs_iso), 256'(1));

    // Limit: two outstanding writes gate the third AW
    isolate = 1'b0;
    step();
    s_req.aw_valid = 1'b1; m_resp.aw_ready = 1'b1;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("limit_aw_ready", 256'(obs_resp.aw_ready), 256'(0));
      check("limit_aw_valid", 256'(obs_req.aw_valid), 256'(0));
    end
    m_resp.b_valid = 1'b1; s_req.b_ready = 1'b1;
    step(); check("limit_b_cycle_aw_ready", 256'(obs_resp.aw_ready), 256'(0));
    step(); check("limit_aw_and_b_aw_ready", 256'(obs_resp.aw_ready), 256'(1));
    m_resp.b_valid = 1'b0; s_req.b_ready = 1'b0;
    step(); check("limit_after_both_aw_ready", 256'(obs_resp.aw_ready), 256'(1));
    step(); check("limit_full_again_aw_ready", 256'(obs_resp.aw_ready), 256'(0));
    s_req.aw_valid = 1'b0; m_resp.aw_ready = 1'b0;

    // Reset while draining two writes
    isolate = 1'b1;
    step(); step();
    check("drain2_iso", 256'(obs_iso), 256'(0));
    rst_n = 1'b0; isolate = 1'b0;
    step(); check("rst_mid_iso", 256'(obs_iso), 256'(0));
    rst_n = 1'b1;
    s_req.aw_valid = 1'b1; m_resp.aw_ready = 1'b1;
    step();
    check("post_rst_aw_ready", 256'(obs_resp.aw_ready), 256'(1));
    check("post_rst_aw_valid", 256'(obs_req.aw_valid), 256'(1));
    check("post_rst_iso", 256'(obs_iso), 256'(0));
    s_req.aw_valid = 1'b0; m_resp.aw_ready = 1'b0;
    m_resp.b_valid = 1'b1; s_req.b_ready = 1'b1;
    step();
    m_resp.b_valid = 1'b0; s_req.b_ready = 1'b0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rand_payload();
      if ($urandom_range(0, 19) == 0) isolate = ~isolate;
      s_req.aw_valid  = 1'($urandom_range(0, 1));
      s_req.ar_valid  = 1'($urandom_range(0, 1));
      s_req.w_valid   = 1'($urandom_range(0, 1));
      s_req.b_ready   = 1'($urandom_range(0, 1));
      s_req.r_ready   = 1'($urandom_range(0, 1));
      m_resp.aw_ready = 1'($urandom_range(0, 1));
      m_resp.ar_ready = 1'($urandom_range(0, 1));
      m_resp.w_ready  = 1'($urandom_range(0, 1));
      m_resp.b_valid  = (cnt[0] > 0) && ($urandom_range(0, 1) == 1);
      m_resp.r_valid  = (cnt[1] > 0) && ($urandom_range(0, 1) == 1);
      m_resp.r.last   = ($urandom_range(0, 2) == 0);
      step();
    end

    // Final drain to isolation within a bounded number of cycles
    isolate = 1'b1;
    s_req.w_valid = 1'b0; m_resp.w_ready = 1'b0;
    s_req.b_ready = 1'b1; s_req.r_ready = 1'b1;
    m_resp.aw_ready = 1'b1; m_resp.ar_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      s_req.aw_valid = (ph[0] == STUCK);
      s_req.ar_valid = (ph[1] == STUCK);
      m_resp.b_valid = (cnt[0] > 0);
      m_resp.r_valid = (cnt[1] > 0);
      m_resp.r.last  = 1'b1;
      step();
      if (obs_iso) break;
    end
    check("final_isolated", 256'(obs_iso), 256'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
